bcd_time_counter: RTL
=====================

// Module: bcd_time_counter
// PURPOSE
// - Time-of-day engine feeding the 7-segment display stage: divides CLOCK_50 down to a 100 Hz tick.
// - Keeps packed BCD time HH:MM:SS:CC (CC = hundredths); time_out drives the display decoder directly.
// - Owns field loading from switches, the alarm register, and alarm match/ring timing.
// PARAMETERS
// - CLK_HZ      50_000_000  input clock frequency; prescaler terminal count = CLK_HZ/TICK_HZ-1
// - TICK_HZ     100         hundredths tick rate; CLK_HZ must be an integer multiple
// - ALARM_SECS  10          ring duration in seconds (1..255)
// PORTS
// - CLOCK_50     in   1   system clock, all logic on rising edge
// - RESET_N      in   1   asynchronous active-low reset
// - time_in      in   8   BCD field value {tens,units} for loads
// - set_hour/set_minute/set_second/set_mil  in 1 each  field select (level)
// - set_time     in   1   load-strobe to time register (rising edge detected in CLOCK_50 domain)
// - set_alarm    in   1   load-strobe to alarm register (rising edge detected)
// - alarm_en     in   1   arms alarm matching (level)
// - alarm_ack    in   1   silences ringing alarm (level, sampled each cycle)
// - time_out     out  32  {HH,MM,SS,CC} packed BCD, 4 bits per digit, MS digit at [31:28]
// - alarm_out    out  32  alarm register, same packing
// - tick         out  1   one-cycle pulse per hundredths increment
// - alarm_sound  out  1   high while ringing
// - load_err     out  1   one-cycle pulse on rejected load
// - pm           out  1   PM flag (12-hour build only; constant 0 otherwise)
// BEHAVIOUR
// - Reset: time_out=0, alarm_out=0, prescaler=0, tick=0, alarm_sound=0, load_err=0, pm=0, edge regs=0.
//   12h build resets hours to 8'h12 (pm=0). Async assert, sync release.
// - Strobe inputs pass through 2-FF synchronisers; load acts on cycle after synchronised rising edge.
// - Prescaler counts 0..CLK_HZ/TICK_HZ-1; tick pulses on terminal count; wraps to 0.
// - On tick, BCD cascade: CC 00..99 -> SS 00..59 -> MM 00..59 -> HH 00..23 -> 00 (midnight wrap).
//   Each digit increments units 0..9 then tens; carry only at field max. Never emits non-BCD.
// - Load: field select priority hour > minute > second > mil; none selected -> no-op, no error.
//   Validity: both nibbles <=9 AND value <= field max (HH 23, MM/SS 59, CC 99); else reject,
//   register unchanged, load_err pulses 1 cycle.
// - set_time and set_alarm edges same cycle: set_time wins, set_alarm edge dropped.
// - Valid time load clears prescaler to 0 and suppresses any tick in that cycle (load wins).
// - Alarm match: on a tick where the new time has CC==00 and HH:MM:SS == alarm_out[31:8],
//   with alarm_en=1 -> alarm_sound rises the next cycle; alarm_out[7:0] ignored for match.
// - Ringing: down-counter loaded with ALARM_SECS, decremented on each SS increment; sound drops at 0,
//   on alarm_ack=1, or alarm_en=0 (each takes effect next cycle). Match while ringing reloads counter.
// - alarm_ack held high blocks new rings. Reset mid-ring clears sound and counter immediately.
// CONFIGURATION
// - TWELVE_HOUR_EN defined: hours count 12,01..11,12; pm toggles on 11:59:59:99 -> 12:00:00:00;
//   valid hour loads 01..12 (00 and >12 rejected); alarm load checked against same range, and
//   match additionally requires alarm pm state = pm (alarm pm latched from pm at alarm load).
// - Undefined: 24-hour behaviour above, pm tied 0.
// TESTING
// - Reset with CLK_HZ=1000: time_out=0, alarm_sound=0; 10 clocks/tick, first tick at cycle 10.
// - Load 23:59:59:99 via four set_time loads, one tick -> time_out=32'h00000000, midnight wrap.
// - Load set_minute time_in=8'h60 and 8'h1A -> load_err pulse each, time_out unchanged.
// - Alarm 00:00:05, alarm_en=1, time 00:00:04:99, one tick -> alarm_sound=1 next cycle,
//   clears after ALARM_SECS seconds; repeat with alarm_ack at 2 s -> clears next cycle.
// - Simultaneous set_time & set_alarm edges with set_hour, time_in=8'h07 -> time HH=07, alarm unchanged.
// - TWELVE_HOUR_EN: 11:59:59:99 pm=0, one tick -> 12:00:00:00 pm=1; load hour 8'h00 -> load_err.

Source files
------------

// File: rtl/bcd_time_counter.sv
// bcd_time_counter: time-of-day engine producing packed BCD HH:MM:SS:CC for the display stage.
// Divides CLOCK_50 to a hundredths tick, loads fields from switches, and owns the alarm register and ring timing.
// Build option: define TWELVE_HOUR_EN for 12-hour counting (12,01..11) with a PM flag; otherwise 24-hour, pm tied 0.
// RESET_N asserts asynchronously; its release is expected to be synchronised upstream.
module bcd_time_counter #(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned TICK_HZ    = 100,
    parameter int unsigned ALARM_SECS = 10
) (
    input  logic        CLOCK_50,
    input  logic        RESET_N,
    input  logic [7:0]  time_in,
    input  logic        set_hour,
    input  logic        set_minute,
    input  logic        set_second,
    input  logic        set_mil,
    input  logic        set_time,
    input  logic        set_alarm,
    input  logic        alarm_en,
    input  logic        alarm_ack,
    output logic [31:0] time_out,
    output logic [31:0] alarm_out,
    output logic        tick,
    output logic        alarm_sound,
    output logic        load_err,
    output logic        pm
);

    localparam int unsigned DIV    = CLK_HZ / TICK_HZ;
    localparam int unsigned PRE_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned RING_W = 8;

    localparam logic [PRE_W-1:0]  PRE_TC    = PRE_W'(DIV - 1);
    localparam logic [RING_W-1:0] RING_LOAD = RING_W'(ALARM_SECS);

    localparam logic [0:0] RING_IDLE = 1'b0;
    localparam logic [0:0] RING_ON   = 1'b1;

`ifdef TWELVE_HOUR_EN
    localparam logic [7:0] HR_MAX = 8'h12;
    localparam logic [7:0] HR_RST = 8'h12;
`else
    localparam logic [7:0] HR_MAX = 8'h23;
    localparam logic [7:0] HR_RST = 8'h00;
`endif

    // BCD increment of a two-digit field (caller handles field wrap).
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v[3:0] == 4'd9) bcd_inc = {v[7:4] + 4'd1, 4'd0};
        else                bcd_inc = {v[7:4], v[3:0] + 4'd1};
    endfunction

    // Both nibbles decimal and value not above the field maximum.
    function automatic logic bcd_le(input logic [7:0] v, input logic [7:0] hi);
        bcd_le = (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= hi);
    endfunction

    logic [2:0]        st_sync, al_sync;
    logic [PRE_W-1:0]  presc;
    logic [0:0]        ring_state, ring_nxt;
    logic [RING_W-1:0] ring_cnt, cnt_nxt;

    logic        st_edge_c, al_edge_c, fsel_any_c, val_ok_c;
    logic [1:0]  fsel_c;
    logic [7:0]  fmax_c;
    logic        time_load_c, alarm_load_c, err_c, tick_c, ss_inc_c, match_c, pm_match_c;
    logic        cc_wrap_c, ss_wrap_c, mm_wrap_c, hr_carry_c, pm_flip_c;
    logic [7:0]  nxt_cc_c, nxt_ss_c, nxt_mm_c, nxt_hh_c;
    logic [31:0] time_inc_c, time_nxt_c, alarm_nxt_c;

    assign st_edge_c  = st_sync[1] & ~st_sync[2];
    assign al_edge_c  = al_sync[1] & ~al_sync[2];
    assign fsel_any_c = set_hour | set_minute | set_second | set_mil;

    // Field select priority and load validity (hour > minute > second > hundredths).
    always_comb begin
        fsel_c = 2'd0;
        fmax_c = 8'h99;
        if (set_hour) begin
            fsel_c = 2'd3;
            fmax_c = HR_MAX;
        end else if (set_minute) begin
            fsel_c = 2'd2;
            fmax_c = 8'h59;
        end else if (set_second) begin
            fsel_c = 2'd1;
            fmax_c = 8'h59;
        end
`ifdef TWELVE_HOUR_EN
        val_ok_c = bcd_le(time_in, fmax_c) && !((fsel_c == 2'd3) && (time_in == 8'h00));
`else
        val_ok_c = bcd_le(time_in, fmax_c);
`endif
    end

    // A set_time edge always claims the cycle; a coincident set_alarm edge is dropped.
    assign time_load_c  = st_edge_c & fsel_any_c & val_ok_c;
    assign alarm_load_c = al_edge_c & ~st_edge_c & fsel_any_c & val_ok_c;
    assign err_c        = (st_edge_c | al_edge_c) & fsel_any_c & ~val_ok_c;
    assign tick_c       = (presc == PRE_TC) & ~time_load_c;

    // BCD cascade CC -> SS -> MM -> HH with wrap at each field maximum.
    always_comb begin
        cc_wrap_c  = (time_out[7:0] == 8'h99);
        ss_wrap_c  = (time_out[15:8] == 8'h59);
        mm_wrap_c  = (time_out[23:16] == 8'h59);
        hr_carry_c = cc_wrap_c & ss_wrap_c & mm_wrap_c;
        nxt_cc_c   = cc_wrap_c ? 8'h00 : bcd_inc(time_out[7:0]);
        nxt_ss_c   = time_out[15:8];
        nxt_mm_c   = time_out[23:16];
        nxt_hh_c   = time_out[31:24];
        pm_flip_c  = 1'b0;
        if (cc_wrap_c) nxt_ss_c = ss_wrap_c ? 8'h00 : bcd_inc(time_out[15:8]);
        if (cc_wrap_c && ss_wrap_c) nxt_mm_c = mm_wrap_c ? 8'h00 : bcd_inc(time_out[23:16]);
        if (hr_carry_c) begin
`ifdef TWELVE_HOUR_EN
            nxt_hh_c  = (time_out[31:24] == 8'h12) ? 8'h01 : bcd_inc(time_out[31:24]);
            pm_flip_c = (time_out[31:24] == 8'h11);
`else
            nxt_hh_c  = (time_out[31:24] == 8'h23) ? 8'h00 : bcd_inc(time_out[31:24]);
`endif
        end
        time_inc_c = {nxt_hh_c, nxt_mm_c, nxt_ss_c, nxt_cc_c};
    end

    // Next time/alarm register values: a valid load wins over the tick.
    always_comb begin
        time_nxt_c  = time_out;
        alarm_nxt_c = alarm_out;
        if (time_load_c) begin
            case (fsel_c)
                2'd3:    time_nxt_c[31:24] = time_in;
                2'd2:    time_nxt_c[23:16] = time_in;
                2'd1:    time_nxt_c[15:8]  = time_in;
                default: time_nxt_c[7:0]   = time_in;
            endcase
        end else if (tick_c) begin
            time_nxt_c = time_inc_c;
        end
        if (alarm_load_c) begin
            case (fsel_c)
                2'd3:    alarm_nxt_c[31:24] = time_in;
                2'd2:    alarm_nxt_c[23:16] = time_in;
                2'd1:    alarm_nxt_c[15:8]  = time_in;
                default: alarm_nxt_c[7:0]   = time_in;
            endcase
        end
    end

    assign ss_inc_c = tick_c & cc_wrap_c;
    assign match_c  = tick_c & alarm_en & ~alarm_ack & pm_match_c & (nxt_cc_c == 8'h00)
                    & ({nxt_hh_c, nxt_mm_c, nxt_ss_c} == alarm_out[31:8]);

`ifdef TWELVE_HOUR_EN
    logic alarm_pm;
    assign pm_match_c = (alarm_pm == (pm ^ pm_flip_c));

    // PM flag follows the 11 -> 12 hour rollover; alarm PM latched at alarm load.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            pm       <= 1'b0;
            alarm_pm <= 1'b0;
        end else begin
            if (tick_c && pm_flip_c) pm <= ~pm;
            if (alarm_load_c) alarm_pm <= pm;
        end
    end
`else
    assign pm_match_c = 1'b1;
    assign pm         = 1'b0;
`endif

    // Ring FSM state register.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) ring_state <= RING_IDLE;
        else          ring_state <= ring_nxt;
    end

    // Ring next state: match (re)arms the seconds counter; ack, disable or expiry silences.
    always_comb begin
        ring_nxt = ring_state;
        cnt_nxt  = ring_cnt;
        case (ring_state)
            RING_IDLE: begin
                if (match_c) begin
                    ring_nxt = RING_ON;
                    cnt_nxt  = RING_LOAD;
                end
            end
            default: begin
                if (match_c) begin
                    cnt_nxt = RING_LOAD;
                end else if (alarm_ack || !alarm_en || (ring_cnt == '0)) begin
                    ring_nxt = RING_IDLE;
                    cnt_nxt  = '0;
                end else if (ss_inc_c) begin
                    cnt_nxt = ring_cnt - RING_W'(1);
                end
            end
        endcase
    end

    assign alarm_sound = (ring_state == RING_ON);

    // Strobe synchronisers, prescaler, time/alarm registers and pulse outputs.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            st_sync   <= '0;
            al_sync   <= '0;
            presc     <= '0;
            time_out  <= {HR_RST, 24'h0};
            alarm_out <= '0;
            tick      <= 1'b0;
            load_err  <= 1'b0;
            ring_cnt  <= '0;
        end else begin
            st_sync   <= {st_sync[1:0], set_time};
            al_sync   <= {al_sync[1:0], set_alarm};
            presc     <= (time_load_c || (presc == PRE_TC)) ? '0 : presc + PRE_W'(1);
            time_out  <= time_nxt_c;
            alarm_out <= alarm_nxt_c;
            tick      <= tick_c;
            load_err  <= err_c;
            ring_cnt  <= cnt_nxt;
        end
    end

endmodule
